mdio_init_sequencer: RTL
========================

MDIO_INIT_SEQUENCER -- requirements
Module: mdio_init_sequencer

Interface
REQ-001 Parameter CLKS_STARTUP, default 125000: cycles to wait after reset before the first command (1 ms at 125 MHz).
REQ-002 Parameter GAP_CYCLES, default 64: idle cycles between one completed frame and the next command.
REQ-003 Parameter TIMEOUT_CYCLES, default 20000: maximum cycles allowed from command acceptance to wr_done.
REQ-004 Parameter PHY_ADDRESS, default 5'h0c: PHY address driven on every command.
REQ-005 Parameter NUM_ENTRIES, default 2, legal range 1..4: number of table entries issued.
REQ-006 Parameters REG_ADDR_0..3 (5 bits) and DATA_0..3 (16 bits); defaults: entry 0 = 5'h18/16'h0030, entry 1 = 5'h00/16'h1140, entries 2..3 = 0.
REQ-007 clk  input  1  system clock, 125 MHz.
REQ-008 reset  input  1  reset, synchronous to clk, active-low (0 = reset).
REQ-009 restart  input  1  single-cycle request to rerun the table from entry 0.
REQ-010 cmd_valid  output  1  command presented to the downstream MDIO frame writer.
REQ-011 cmd_ready  input  1  downstream writer can accept a command.
REQ-012 cmd_phy_addr  output  5  PHY address of the command.
REQ-013 cmd_reg_addr  output  5  register address of the command.
REQ-014 cmd_data  output  16  register write data.
REQ-015 wr_done  input  1  single-cycle pulse from the writer when the frame's last data bit completes.
REQ-016 busy  output  1  high in every state except DONE and ERROR.
REQ-017 seq_done  output  1  high while in DONE.
REQ-018 seq_error  output  1  high while in ERROR.
REQ-019 err_index  output  2  index of the entry that timed out; valid while seq_error is high.

Function
REQ-020 States: STARTUP, ISSUE, WAIT_DONE, GAP, DONE, ERROR; all outputs are registered.
REQ-021 STARTUP: counter runs from 0 and moves to ISSUE with index 0 in the cycle after the count reaches CLKS_STARTUP-1.
REQ-022 ISSUE: cmd_valid=1 and cmd_* = table[index]; the transfer occurs on a clk edge where cmd_valid && cmd_ready.
REQ-023 On transfer, cmd_valid drops in the next cycle, the timeout counter clears and the state moves to WAIT_DONE.
REQ-024 While cmd_valid=1, cmd_phy_addr, cmd_reg_addr and cmd_data are held stable; cmd_valid does not depend on cmd_ready.
REQ-025 Outside ISSUE, cmd_valid=0 and cmd_* hold their last values.
REQ-026 WAIT_DONE, on wr_done: move to GAP and clear the gap counter.
REQ-027 WAIT_DONE, timeout: if the counter reaches TIMEOUT_CYCLES-1 without wr_done, move to ERROR and latch err_index=index.
REQ-028 WAIT_DONE, tie: wr_done in the same cycle as the timeout terminal count counts as success.
REQ-029 GAP: after GAP_CYCLES cycles, go to ISSUE with index+1 if index < NUM_ENTRIES-1, else go to DONE.
REQ-030 wr_done received in STARTUP, ISSUE, GAP, DONE or ERROR is ignored.
REQ-031 restart in DONE or ERROR: next state ISSUE, index=0, seq_error clears; the startup delay is not repeated.
REQ-032 restart in any other state is ignored; no queuing.
REQ-033 Counters are wide enough for the largest parameter value and never wrap within a state.
REQ-034 index is 2 bits, increments only in GAP, and never exceeds NUM_ENTRIES-1.

Reset
REQ-035 reset=0 sampled on a clk edge gives: state STARTUP, all counters 0, index 0, cmd_valid 0, cmd_phy_addr/cmd_reg_addr/cmd_data 0, busy 1, seq_done 0, seq_error 0, err_index 0.
REQ-036 Reset asserted mid-transaction (including ISSUE with cmd_valid=1) drops cmd_valid on the next edge; no partial command is retained.

Verification (CLKS_STARTUP=10, GAP_CYCLES=4, TIMEOUT_CYCLES=50, default table)
REQ-037 Startup: release reset, cmd_ready=1 -> first cmd_valid exactly 10 cycles after reset release, with cmd_phy_addr=0x0c, cmd_reg_addr=0x18, cmd_data=0x0030.
REQ-038 Full run: wr_done 20 cycles after each transfer -> entry 1 (0x00/0x1140) issued 4 cycles after the first wr_done; seq_done=1 and busy=0 after the second frame plus the gap.
REQ-039 Backpressure: cmd_ready low for 7 cycles during ISSUE -> cmd_valid and cmd_* held constant for all 7 cycles; exactly one transfer occurs.
REQ-040 Timeout: no wr_done after the entry-1 transfer -> seq_error=1 and err_index=1 exactly 50 cycles after the transfer; cmd_valid stays 0.
REQ-041 Restart from ERROR: restart pulse -> cmd_valid next cycle with entry 0, seq_error cleared; a restart pulse during WAIT_DONE has no effect.
REQ-042 Reset mid-ISSUE: reset=0 while cmd_valid=1 -> cmd_valid=0 on the next edge; full startup delay restarts after reset release.

Source files
------------

// File: rtl/mdio_init_sequencer.sv
// ---------------------------------------------------------------------------
// mdio_init_sequencer
//
// Walks a small parameterised table of PHY register writes after power-up and
// hands each one to a downstream MDIO frame writer through a valid/ready
// command port. It waits for the writer's completion pulse before moving on,
// leaves a fixed idle gap between frames, and reports a timeout if a frame
// never completes.
//
// Ports:
//   i_clk            system clock
//   i_reset          synchronous reset, active low
//   i_restart        one-cycle request to rerun the table (DONE/ERROR only)
//   o_cmd_valid      command offered to the frame writer
//   i_cmd_ready      frame writer can take the command
//   o_cmd_phy_addr   PHY address of the command
//   o_cmd_reg_addr   register address of the command
//   o_cmd_data       register write data
//   i_wr_done        one-cycle pulse when the frame's last bit has gone out
//   o_busy           sequencer is working (not DONE, not ERROR)
//   o_seq_done       whole table written
//   o_seq_error      a frame timed out
//   o_err_index      table index of the frame that timed out
// ---------------------------------------------------------------------------
module mdio_init_sequencer #(
    parameter int unsigned CLKS_STARTUP   = 125000,
    parameter int unsigned GAP_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter logic [4:0]  PHY_ADDRESS    = 5'h0c,
    parameter int unsigned NUM_ENTRIES    = 2,
    parameter logic [4:0]  REG_ADDR_0     = 5'h18,
    parameter logic [15:0] DATA_0         = 16'h0030,
    parameter logic [4:0]  REG_ADDR_1     = 5'h00,
    parameter logic [15:0] DATA_1         = 16'h1140,
    parameter logic [4:0]  REG_ADDR_2     = 5'h00,
    parameter logic [15:0] DATA_2         = 16'h0000,
    parameter logic [4:0]  REG_ADDR_3     = 5'h00,
    parameter logic [15:0] DATA_3         = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_restart,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ready,
    output logic [4:0]  o_cmd_phy_addr,
    output logic [4:0]  o_cmd_reg_addr,
    output logic [15:0] o_cmd_data,
    input  logic        i_wr_done,
    output logic        o_busy,
    output logic        o_seq_done,
    output logic        o_seq_error,
    output logic [1:0]  o_err_index
);

    // One counter serves all timed states; it is cleared on every state
    // change, so it only has to cover the largest of the three intervals.
    localparam int unsigned CNT_MAX_A = (CLKS_STARTUP > GAP_CYCLES) ? CLKS_STARTUP : GAP_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(CLKS_STARTUP - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       LAST_IDX     = 2'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        S_STARTUP,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_nxt;
    logic [20:0]      w_entry;

    // Table lookup: {reg_addr, data} for a given index.
    function automatic logic [20:0] tbl_entry(input logic [1:0] idx);
        logic [20:0] e;
        case (idx)
            2'd0:    e = {REG_ADDR_0, DATA_0};
            2'd1:    e = {REG_ADDR_1, DATA_1};
            2'd2:    e = {REG_ADDR_2, DATA_2};
            default: e = {REG_ADDR_3, DATA_3};
        endcase
        return e;
    endfunction

    assign w_entry = tbl_entry(w_idx_nxt);

    // Next-state logic. Every transition clears the counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_STARTUP: begin
                if (r_cnt == STARTUP_LAST) begin
                    w_state_nxt = S_ISSUE;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (o_cmd_valid && i_cmd_ready) begin
                    w_state_nxt = S_WAIT_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_DONE: begin
                // A completion on the terminal-count cycle still wins.
                if (i_wr_done) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = S_ERROR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx < LAST_IDX) begin
                        w_state_nxt = S_ISSUE;
                        w_idx_nxt   = r_idx + 2'd1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE, S_ERROR: begin
                // Rerun skips the startup wait; the PHY is already alive.
                if (i_restart) begin
                    w_state_nxt = S_ISSUE;
                    w_idx_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_STARTUP;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    // State, counters and registered outputs. Outputs are computed from the
    // next state so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state        <= S_STARTUP;
            r_cnt          <= '0;
            r_idx          <= 2'd0;
            o_cmd_valid    <= 1'b0;
            o_cmd_phy_addr <= 5'd0;
            o_cmd_reg_addr <= 5'd0;
            o_cmd_data     <= 16'd0;
            o_busy         <= 1'b1;
            o_seq_done     <= 1'b0;
            o_seq_error    <= 1'b0;
            o_err_index    <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            o_cmd_valid <= (w_state_nxt == S_ISSUE);
            o_busy      <= (w_state_nxt != S_DONE) && (w_state_nxt != S_ERROR);
            o_seq_done  <= (w_state_nxt == S_DONE);
            o_seq_error <= (w_state_nxt == S_ERROR);
            // Command fields load only on entry to ISSUE, so they stay frozen
            // under backpressure and keep their last value afterwards.
            if ((w_state_nxt == S_ISSUE) && (r_state != S_ISSUE)) begin
                o_cmd_phy_addr <= PHY_ADDRESS;
                o_cmd_reg_addr <= w_entry[20:16];
                o_cmd_data     <= w_entry[15:0];
            end
            if ((r_state == S_WAIT_DONE) && (w_state_nxt == S_ERROR)) begin
                o_err_index <= r_idx;
            end
        end
    end

endmodule
